fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 83 ++++++++
 tb/tb_fetch_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling buffer: circular FIFO of if_id_stage_t packets.
// One-cycle latency, flush has priority, exception-only packets are buffered.
package fetch_buffer_pkg;
  localparam logic [31:0] INSTR_ADDR_MISALIGNED = 32'd0;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] origin;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bpred_t;

  typedef struct packed {
    logic [31:0] pc_inst;
    logic [31:0] inst;
    logic        valid;
    bpred_t      bpred;
    exception_t  ex;
  } if_id_stage_t;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  if_id_stage_t             fetch_i,
  input  logic                     flush_i,
  input  logic                     ready_i,
  output if_id_stage_t             decode_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if_id_stage_t    mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            push_req, pop, push;

  assign full_o   = (count == CW'(DEPTH));
  assign empty_o  = (count == '0);
  assign count_o  = count;

  assign push_req = fetch_i.valid | fetch_i.ex.valid;
  assign pop      = ready_i & ~empty_o;
  assign push     = push_req & ~flush_i & (~full_o | pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= fetch_i;
  end

  assign decode_o = empty_o ? '0 : mem[rptr];
endmodule

// File: tb/tb_fetch_buffer.sv
// Scenario bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 0, rstn = 0, flush = 0, ready = 0;
  if_id_stage_t fetch = '0;
  if_id_stage_t decode;
  logic full, empty;
  logic [CW-1:0] count;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn), .fetch_i(fetch), .flush_i(flush), .ready_i(ready),
    .decode_o(decode), .full_o(full), .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  if_id_stage_t q[$];
  int nvec = 0, nerr = 0;

  function automatic if_id_stage_t head();
    if (q.size() > 0) return q[0];
    return '0;
  endfunction

  function automatic if_id_stage_t mk(logic [31:0] pc, logic v, logic exv);
    if_id_stage_t p = '0;
    p.pc_inst = pc;
    p.inst = $urandom;
    p.valid = v;
    p.bpred.taken = 1'($urandom);
    p.bpred.target = $urandom;
    p.ex.valid = exv;
    if (exv) begin
      p.ex.cause = $urandom_range(0, 15);
      p.ex.origin = pc;
    end
    return p;
  endfunction

  task automatic apply(if_id_stage_t p, logic fl, logic rd);
    @(negedge clk);
    fetch = p; flush = fl; ready = rd;
  endtask

  // Reference: queue semantics straight from the push/pop/flush rules.
  task automatic tick();
    bit pop_m, push_m;
    @(posedge clk);
    pop_m  = ready && q.size() > 0;
    push_m = (fetch.valid || fetch.ex.valid) && !flush && (q.size() < DEPTH || pop_m);
    if (flush) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(fetch);
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    #12;
    nvec++;
    if (count !== 0 || full !== 0 || empty !== 1) begin
      nerr++; $display("FAIL reset_status: count=%0d full=%0b empty=%0b want 0/0/1", count, full, empty);
    end
    nvec++;
    if (decode.valid !== 0 || decode.ex.valid !== 0) begin
      nerr++; $display("FAIL reset_decode: valid=%0b ex.valid=%0b want 0/0", decode.valid, decode.ex.valid);
    end
    @(negedge clk); rstn = 1;
    q.delete();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      apply(mk(32'h200 + 32'(4*i), 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
    end
    apply('0, 1'b0, 1'b0);
    nvec++;
    if (count !== 3) begin nerr++; $display("FAIL basic_count: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (decode.pc_inst !== 32'h200 + 32'(4*i) || decode !== head()) begin
        nerr++; $display("FAIL basic_order%0d: got pc %h want %h", i, decode.pc_inst, 32'h200 + 32'(4*i));
      end
      apply('0, 1'b0, 1'b1);
      tick();
    end
    nvec++;
    if (empty !== 1 || count !== 0) begin
      nerr++; $display("FAIL basic_empty: empty=%0b count=%0d want 1/0", empty, count);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] want;
    for (int i = 0; i < 5; i++) begin
      apply(mk(32'h200 + 32'(4*i), 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
      nvec++;
      if (full !== (i >= 3) || count !== CW'(q.size())) begin
        nerr++; $display("FAIL full_fill%0d: full=%0b count=%0d want %0b/%0d", i, full, count, (i >= 3), q.size());
      end
    end
    want = 32'h200;
    for (int i = 0; i < 6; i++) begin
      apply(mk(32'h214 + 32'(4*i), 1'b1, 1'b0), 1'b0, 1'b1);
      nvec++;
      if (decode.pc_inst !== want) begin
        nerr++; $display("FAIL wrap_order%0d: got pc %h want %h", i, decode.pc_inst, want);
      end
      want = (want == 32'h20c) ? 32'h214 : want + 32'h4;
      tick();
      nvec++;
      if (count !== 4 || full !== 1 || decode !== head()) begin
        nerr++; $display("FAIL wrap_state%0d: count=%0d full=%0b head %h want 4/1 %h", i, count, full, decode, head());
      end
    end
    apply('0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_ex_only();
    if_id_stage_t p = '0;
    p.pc_inst = 32'h202; p.ex.valid = 1; p.ex.cause = INSTR_ADDR_MISALIGNED; p.ex.origin = 32'h202;
    apply(p, 1'b0, 1'b0);
    nvec++;
    if (decode.ex.valid !== 0 || empty !== 1) begin
      nerr++; $display("FAIL ex_bypass: ex.valid=%0b empty=%0b want 0/1", decode.ex.valid, empty);
    end
    tick();
    apply('0, 1'b0, 1'b0);
    nvec++;
    if (decode.ex.valid !== 1 || decode.ex.origin !== 32'h202 || decode.ex.cause !== INSTR_ADDR_MISALIGNED
        || decode.valid !== 0 || count !== 1) begin
      nerr++; $display("FAIL ex_only: got %h want %h count=%0d", decode, p, count);
    end
    apply('0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    if_id_stage_t h;
    for (int i = 0; i < 3; i++) begin
      apply(mk(32'h400 + 32'(4*i), 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
    end
    h = head();
    apply(mk(32'h40c, 1'b1, 1'b0), 1'b1, 1'b1);
    #1;
    nvec++;
    if (count !== 3 || decode !== h) begin
      nerr++; $display("FAIL flush_pre: count=%0d head %h want 3 %h", count, decode, h);
    end
    tick();
    apply('0, 1'b0, 1'b0);
    nvec++;
    if (count !== 0 || empty !== 1 || decode.valid !== 0 || q.size() != 0) begin
      nerr++; $display("FAIL flush_post: count=%0d empty=%0b valid=%0b want 0/1/0", count, empty, decode.valid);
    end
    tick();
    nvec++;
    if (count !== 0 || decode !== '0) begin
      nerr++; $display("FAIL flush_absent: count=%0d decode %h want 0", count, decode);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      apply(mk(32'h500 + 32'(4*i), 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
    end
    apply('0, 1'b0, 1'b0);
    #1;
    rstn = 0;
    #1;
    q.delete();
    nvec++;
    if (empty !== 1 || count !== 0 || full !== 0 || decode.valid !== 0 || decode.ex.valid !== 0) begin
      nerr++; $display("FAIL rst_mid: empty=%0b count=%0d valid=%0b want 1/0/0", empty, count, decode.valid);
    end
    @(negedge clk); rstn = 1;
    apply(mk(32'h300, 1'b1, 1'b0), 1'b0, 1'b0);
    tick();
    apply('0, 1'b0, 1'b0);
    nvec++;
    if (decode.pc_inst !== 32'h300 || count !== 1 || decode !== head()) begin
      nerr++; $display("FAIL rst_first: got pc %h count=%0d want 300/1", decode.pc_inst, count);
    end
    apply('0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_empty();
    for (int i = 0; i < 4; i++) begin
      apply('0, 1'b0, 1'b1);
      tick();
      nvec++;
      if (count !== 0 || empty !== 1 || decode.valid !== 0 || decode.ex.valid !== 0 || decode !== '0) begin
        nerr++; $display("FAIL empty%0d: count=%0d decode %h want 0", i, count, decode);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(mk($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0));
      tick();
      nvec++;
      if (count !== CW'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        nerr++; $display("FAIL rand_status%0d: count=%0d full=%0b empty=%0b want %0d", i, count, full, empty, q.size());
      end
      nvec++;
      if (decode !== head()) begin
        nerr++; $display("FAIL rand_head%0d: got %h want %h", i, decode, head());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_ex_only();
    test_flush();
    test_reset_mid();
    test_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
